ones_comp_addsub_seq: RTL and testbench
=======================================

ONES_COMP_ADDSUB_SEQ -- requirements
Module: ones_comp_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 4..32.
REQ-002 Parameter SLICE, default 1: bits processed per cycle; SHALL divide WIDTH; K = WIDTH/SLICE.
REQ-003 Parameter NORM_ZERO, default 0: when 1, a negative-zero result (all ones) is replaced by all zeros.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operands and Sub are valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 A  input  WIDTH  ones'-complement operand A.
REQ-009 B  input  WIDTH  ones'-complement operand B.
REQ-010 Sub  input  1  0: A+B; 1: A-B, computed as A + ~B.
REQ-011 out_valid  output  1  Result and Overflow are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 Result  output  WIDTH  ones'-complement sum or difference.
REQ-014 Overflow  output  1  signed ones'-complement overflow.

Function
REQ-015 States SHALL be IDLE, PASS1, PASS2, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 In IDLE, in_valid=1 SHALL capture A, B' (B, or ~B when Sub=1), and Sub, clear the slice index and carry, and enter PASS1.
REQ-017 PASS1: each cycle adds slice i of A and B' plus the running carry, writes slice i of the accumulator, and advances i; slice 0 is the LSBs.
REQ-018 After slice K-1, a carry-out of 1 SHALL enter PASS2; a carry-out of 0 SHALL enter DONE.
REQ-019 PASS2 (end-around carry): add 1 into slice 0, then propagate over K slices; PASS2 never generates a further carry-out; after slice K-1, enter DONE.
REQ-020 Latency from the accept edge to out_valid SHALL be exactly K cycles without end-around carry and exactly 2K cycles with it.
REQ-021 Overflow SHALL be 1 iff A[MSB] == B'[MSB] and Result[MSB] != A[MSB]; it is evaluated on the pre-normalisation result.
REQ-022 With NORM_ZERO=1, an all-ones result SHALL be presented as all zeros, with Overflow unaffected.
REQ-023 In DONE, out_ready=1 SHALL return to IDLE; out_ready=0 SHALL hold Result and Overflow stable indefinitely.
REQ-024 Result and Overflow SHALL retain their last values in IDLE until the next DONE; in_valid outside IDLE is ignored; the block never accepts a new operation in the DONE cycle.
REQ-025 Operand inputs SHALL be sampled only at the accept edge; input changes during PASS1/PASS2 have no effect.

Reset
REQ-026 reset=1 at any clock edge SHALL force IDLE, in_ready=1, out_valid=0, Result=0, Overflow=0, slice index=0, carry=0.
REQ-027 Reset asserted mid-PASS1/PASS2/DONE SHALL abandon the operation; no out_valid is produced for it.
REQ-028 reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-029 A shared package SHALL hold the state enumeration and a compile-time check that SLICE divides WIDTH and WIDTH is within 4..32.
REQ-030 A single sub-module ones_slice_add (SLICE-bit ripple adder; ports A, B, Cin, Y, Carry) built from the existing fulladder SHALL perform per-cycle slice arithmetic.

Verification
REQ-031 WIDTH=8, SLICE=1: A=0x05, B=0x03, Sub=0 -> Result=0x08, Overflow=0, out_valid 8 cycles after accept.
REQ-032 A=0x05, B=0x03, Sub=1 -> end-around carry, Result=0x02, Overflow=0, out_valid 16 cycles after accept.
REQ-033 A=0x03, B=0x03, Sub=1 -> Result=0xFF when NORM_ZERO=0 and 0x00 when NORM_ZERO=1, Overflow=0.
REQ-034 A=0x70, B=0x20, Sub=0 -> Result=0x90, Overflow=1; WIDTH=16, SLICE=4, A=0x7FFF, B=0xFFFE (-1), Sub=0 -> Result=0x7FFE after 8 cycles.
REQ-035 out_ready held at 0 for 5 cycles in DONE -> Result/out_valid stable; in_valid pulses are ignored until IDLE.
REQ-036 reset asserted for 1 cycle during PASS2 -> next cycle IDLE, in_ready=1, out_valid=0, Result=0; a following operation is correct.

Source files
------------

// File: rtl/ones_comp_addsub_seq_pkg.sv
// ones_comp_addsub_seq_pkg: shared FSM state type and the WIDTH/SLICE legality check
package ones_comp_addsub_seq_pkg;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  function automatic bit cfg_ok(int width, int slice);
    return width >= 4 && width <= 32 && slice >= 1 && width % slice == 0;
  endfunction
endpackage

// File: rtl/fulladder.sv
// fulladder: one-bit full adder (a, b, cin -> sum, cout)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ones_slice_add.sv
// ones_slice_add: SLICE-bit ripple adder of fulladders (A, B, Cin -> Y, Carry)
module ones_slice_add #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             Cin,
  output logic [SLICE-1:0] Y,
  output logic             Carry
);
  logic [SLICE:0] c;
  assign c[0] = Cin;
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    fulladder u_fa (.a(A[i]), .b(B[i]), .cin(c[i]), .sum(Y[i]), .cout(c[i+1]));
  end
  assign Carry = c[SLICE];
endmodule

// File: rtl/ones_comp_addsub_seq.sv
// ones_comp_addsub_seq: slice-serial ones'-complement A+/-B (clk, reset, in_valid/in_ready + A, B, Sub in; out_valid/out_ready + Result, Overflow out)
module ones_comp_addsub_seq
  import ones_comp_addsub_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SLICE     = 1,
  parameter int NORM_ZERO = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow
);
  localparam int K  = WIDTH / SLICE;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  if (!cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("ones_comp_addsub_seq: WIDTH must be 4..32 and divisible by SLICE");
  end
  state_t                     state;
  logic [IW-1:0]              idx;
  logic                       cy;
  logic [K-1:0][SLICE-1:0]    a_q, b_q, acc, acc_nxt;
  logic [SLICE-1:0]           op_a, op_b, y;
  logic                       co, last, pass1, eac, ovf;
  assign pass1     = state == PASS1;
  assign last      = idx == IW'(K - 1);
  assign op_a      = pass1 ? a_q[idx] : acc[idx];
  assign op_b      = pass1 ? b_q[idx] : '0;
  assign eac       = pass1 && co;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = y;
  end
  assign ovf = a_q[K-1][SLICE-1] == b_q[K-1][SLICE-1] && acc_nxt[K-1][SLICE-1] != a_q[K-1][SLICE-1];
  ones_slice_add #(.SLICE(SLICE)) u_add (.A(op_a), .B(op_b), .Cin(cy), .Y(y), .Carry(co));
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cy       <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= A;
          b_q   <= Sub ? ~B : B;
          acc   <= '0;
          idx   <= '0;
          cy    <= 1'b0;
          state <= PASS1;
        end
        PASS1, PASS2: begin
          acc[idx] <= y;
          idx      <= last ? '0 : idx + 1'b1;
          // a PASS1 carry-out re-enters at slice 0 as the end-around carry
          cy       <= last ? eac : co;
          if (last) begin
            if (eac) state <= PASS2;
            else begin
              state    <= DONE;
              Result   <= (NORM_ZERO != 0 && &acc_nxt) ? '0 : acc_nxt;
              Overflow <= ovf;
            end
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ones_comp_addsub_seq.sv
// tb_ones_comp_addsub_seq: directed checks of three configurations (8/1, 8/1 with zero normalisation, 16/4)
module tb_ones_comp_addsub_seq;
  logic clk = 1'b0, reset = 1'b1, sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic iv [3];
  logic ir [3], ovd [3], ovf [3];
  logic [7:0]  r0, r1;
  logic [15:0] r2;
  logic [15:0] res [3];
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  assign res[0] = {8'h00, r0};
  assign res[1] = {8'h00, r1};
  assign res[2] = r2;
  ones_comp_addsub_seq #(.WIDTH(8), .SLICE(1), .NORM_ZERO(0)) d0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[7:0]), .B(b[7:0]), .Sub(sub),
    .out_valid(ovd[0]), .out_ready(out_ready), .Result(r0), .Overflow(ovf[0]));
  ones_comp_addsub_seq #(.WIDTH(8), .SLICE(1), .NORM_ZERO(1)) d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[7:0]), .B(b[7:0]), .Sub(sub),
    .out_valid(ovd[1]), .out_ready(out_ready), .Result(r1), .Overflow(ovf[1]));
  ones_comp_addsub_seq #(.WIDTH(16), .SLICE(4), .NORM_ZERO(0)) d2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .A(a), .B(b), .Sub(sub),
    .out_valid(ovd[2]), .out_ready(out_ready), .Result(r2), .Overflow(ovf[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int w, input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                     input logic [15:0] er, input logic eo, input int el, input string tag);
    int lat;
    @(negedge clk);
    a = xa; b = xb; sub = xs; iv[w] = 1'b1;
    @(posedge clk);
    #1 iv[w] = 1'b0;
    a = ~xa; b = 16'h1234; sub = ~xs;
    lat = 0;
    while (!ovd[w] && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_result"}, {16'h0, res[w]}, {16'h0, er});
    chk({tag, "_overflow"}, {31'h0, ovf[w]}, {31'h0, eo});
  endtask
  task automatic drain(input int w, input string tag);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_in_ready_after_drain"}, {31'h0, ir[w]}, 32'h1);
    chk({tag, "_out_valid_after_drain"}, {31'h0, ovd[w]}, 32'h0);
  endtask
  initial begin
    int cnt;
    foreach (iv[i]) iv[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_in_ready_%0d", i), {31'h0, ir[i]}, 32'h1);
      chk($sformatf("reset_out_valid_%0d", i), {31'h0, ovd[i]}, 32'h0);
      chk($sformatf("reset_result_%0d", i), {16'h0, res[i]}, 32'h0);
      chk($sformatf("reset_overflow_%0d", i), {31'h0, ovf[i]}, 32'h0);
    end
    @(negedge clk) reset = 1'b0;
    run(0, 16'h05, 16'h03, 1'b0, 16'h08, 1'b0, 8, "add_5_3");
    drain(0, "add_5_3");
    run(0, 16'h05, 16'h03, 1'b1, 16'h02, 1'b0, 16, "sub_5_3");
    drain(0, "sub_5_3");
    run(0, 16'h03, 16'h03, 1'b1, 16'hFF, 1'b0, 8, "negzero_raw");
    drain(0, "negzero_raw");
    run(1, 16'h03, 16'h03, 1'b1, 16'h00, 1'b0, 8, "negzero_norm");
    drain(1, "negzero_norm");
    run(0, 16'hFA, 16'hFC, 1'b0, 16'hF7, 1'b0, 16, "add_neg_neg");
    drain(0, "add_neg_neg");
    run(0, 16'h80, 16'hFE, 1'b0, 16'h7F, 1'b1, 16, "neg_overflow");
    drain(0, "neg_overflow");
    run(2, 16'h7FFF, 16'hFFFE, 1'b0, 16'h7FFE, 1'b0, 8, "w16_add_m1");
    drain(2, "w16_add_m1");
    run(0, 16'h70, 16'h20, 1'b0, 16'h90, 1'b1, 8, "pos_overflow");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; a = 16'h11; b = 16'h22; sub = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("stall_out_valid_%0d", i), {31'h0, ovd[0]}, 32'h1);
      chk($sformatf("stall_result_%0d", i), {16'h0, res[0]}, 32'h90);
      chk($sformatf("stall_overflow_%0d", i), {31'h0, ovf[0]}, 32'h1);
      chk($sformatf("stall_in_ready_%0d", i), {31'h0, ir[0]}, 32'h0);
    end
    iv[0] = 1'b0;
    drain(0, "pos_overflow");
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_result", {16'h0, res[0]}, 32'h90);
    chk("idle_hold_overflow", {31'h0, ovf[0]}, 32'h1);
    chk("idle_no_accept", {31'h0, ir[0]}, 32'h1);
    @(negedge clk);
    a = 16'h05; b = 16'h03; sub = 1'b1; iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_in_ready", {31'h0, ir[0]}, 32'h1);
    chk("midreset_out_valid", {31'h0, ovd[0]}, 32'h0);
    chk("midreset_result", {16'h0, res[0]}, 32'h0);
    chk("midreset_overflow", {31'h0, ovf[0]}, 32'h0);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (ovd[0]) cnt++;
    end
    chk("midreset_no_out_valid", 32'(cnt), 32'h0);
    run(0, 16'h05, 16'h03, 1'b0, 16'h08, 1'b0, 8, "post_reset_add");
    drain(0, "post_reset_add");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
